// File: rtl/gpu_fb_arbiter.sv
// gpu_fb_arbiter: sequences every cycle of the single-port frame-buffer SRAM
// between the display scan-out reader and the GPU pixel writer, and owns the
// double-buffer front/back select (swaps land on vsync, between accesses).
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   rd_req/rd_addr -> rd_ack   display read request (level) and accept pulse
//   rd_valid/rd_data           read data return (data held between pulses)
//   wr_valid/wr_addr/wr_data   GPU write, accepted when wr_ready is high
//   swap_req, vsync            frame-complete flush and vertical-blank pulses
//   swap_done, front_sel       exchange pulse and buffer being scanned out
//   sram_*                     physical address, data and active-low strobes
module gpu_fb_arbiter #(
    parameter int unsigned ADDR_BITS  = 20,
    parameter int unsigned DATA_BITS  = 24,
    parameter int unsigned BUF_OFFSET = 307200,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ack,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_valid,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 swap_req,
    input  logic                 vsync,
    output logic                 swap_done,
    output logic                 front_sel,
    output logic [ADDR_BITS:0]   sram_addr,
    output logic [DATA_BITS-1:0] sram_wdata,
    input  logic [DATA_BITS-1:0] sram_rdata,
    output logic                 sram_ce_n,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    localparam int unsigned PA_BITS  = ADDR_BITS + 1;
    localparam int unsigned CNT_BITS = $clog2(STARVE_MAX + 1);
    localparam logic [PA_BITS-1:0]  BUF1_BASE  = PA_BITS'(BUF_OFFSET);
    localparam logic [CNT_BITS-1:0] STARVE_LIM = CNT_BITS'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_CAP = 3'd2,
        WR     = 3'd3,
        WR_REC = 3'd4
    } state_t;

    state_t                state, state_d;
    logic                  pending, pending_d;
    logic                  vsync_seen, vsync_seen_d;
    logic [CNT_BITS-1:0]   starve, starve_d;
    logic                  front_sel_d;
    logic                  rd_ack_d, rd_valid_d, wr_ready_d, swap_done_d;
    logic [DATA_BITS-1:0]  rd_data_d, sram_wdata_d;
    logic [PA_BITS-1:0]    sram_addr_d;
    logic                  ce_n_d, we_n_d, oe_n_d;
    logic                  rd_grant, wr_grant, swap_any, swap_arm;

    // Physical address: buffer base plus logical address, no wrap.
    function automatic logic [PA_BITS-1:0] phys(input logic sel,
                                                input logic [ADDR_BITS-1:0] a);
        return (sel ? BUF1_BASE : PA_BITS'(0)) + PA_BITS'(a);
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            vsync_seen <= 1'b0;
            starve     <= '0;
            front_sel  <= 1'b0;
            rd_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            wr_ready   <= 1'b0;
            swap_done  <= 1'b0;
            rd_data    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            state      <= state_d;
            pending    <= pending_d;
            vsync_seen <= vsync_seen_d;
            starve     <= starve_d;
            front_sel  <= front_sel_d;
            rd_ack     <= rd_ack_d;
            rd_valid   <= rd_valid_d;
            wr_ready   <= wr_ready_d;
            swap_done  <= swap_done_d;
            rd_data    <= rd_data_d;
            sram_addr  <= sram_addr_d;
            sram_wdata <= sram_wdata_d;
            sram_ce_n  <= ce_n_d;
            sram_we_n  <= we_n_d;
            sram_oe_n  <= oe_n_d;
        end
    end

    // Next-state, swap handling, arbitration and strobe sequencing.
    always_comb begin
        state_d      = state;
        pending_d    = pending;
        vsync_seen_d = vsync_seen;
        starve_d     = starve;
        front_sel_d  = front_sel;
        rd_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        wr_ready_d   = 1'b0;
        swap_done_d  = 1'b0;
        rd_data_d    = rd_data;
        sram_addr_d  = sram_addr;
        sram_wdata_d = sram_wdata;
        ce_n_d       = 1'b1;
        we_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        rd_grant     = 1'b0;
        wr_grant     = 1'b0;

        // A vsync seen mid-access is remembered until the FSM is back in IDLE.
        swap_any = pending | swap_req;
        swap_arm = swap_any & (vsync | vsync_seen);
        if (swap_arm && state == IDLE) begin
            front_sel_d  = ~front_sel;
            pending_d    = 1'b0;
            vsync_seen_d = 1'b0;
            swap_done_d  = 1'b1;
        end else if (swap_arm) begin
            pending_d    = 1'b1;
            vsync_seen_d = 1'b1;
        end else begin
            pending_d    = swap_any;
        end

        case (state)
            IDLE: begin
                // Grants address the buffers as they stand after any swap this cycle.
                rd_grant = rd_req && (!wr_valid || starve < STARVE_LIM);
                wr_grant = !rd_grant && wr_valid;
                if (rd_grant) begin
                    rd_ack_d    = 1'b1;
                    sram_addr_d = phys(front_sel_d, rd_addr);
                    state_d     = RD;
                end else if (wr_grant) begin
                    wr_ready_d   = 1'b1;
                    sram_addr_d  = phys(~front_sel_d, wr_addr);
                    sram_wdata_d = wr_data;
                    state_d      = WR;
                end
            end
            RD: begin
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rd_data_d  = sram_rdata;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            WR: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                state_d = WR_REC;
            end
            WR_REC: begin
                ce_n_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Consecutive reads granted over a waiting write.
        if (!wr_valid || wr_grant) begin
            starve_d = '0;
        end else if (rd_grant) begin
            starve_d = starve + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// tb_gpu_fb_arbiter: directed scenarios for gpu_fb_arbiter with a
// combinational SRAM model (read data = address XOR a fixed pattern).
module tb_gpu_fb_arbiter;

    localparam int unsigned AB = 20;
    localparam int unsigned DB = 24;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          rd_req;
    logic [AB-1:0] rd_addr;
    logic          rd_ack, rd_valid;
    logic [DB-1:0] rd_data;
    logic          wr_valid;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
    logic          wr_ready;
    logic          swap_req, vsync, swap_done, front_sel;
    logic [AB:0]   sram_addr;
    logic [DB-1:0] sram_wdata, sram_rdata;
    logic          sram_ce_n, sram_we_n, sram_oe_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_pulses    = 0;

    gpu_fb_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .BUF_OFFSET(307200), .STARVE_MAX(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .swap_req(swap_req), .vsync(vsync), .swap_done(swap_done), .front_sel(front_sel),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? (DB'(sram_addr) ^ 24'h5A5A5A) : 24'h000000;

    // Count cycles with the write strobe low.
    always @(posedge clk) begin
        if (n_rst && !sram_ce_n && !sram_we_n) wr_pulses = wr_pulses + 1;
    end

    task automatic test_reset();
        n_rst = 1'b0; rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0;
        wr_data = '0; swap_req = 0; vsync = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rd_ack, rd_valid, wr_ready, swap_done, front_sel} !== 5'b00000) begin
            tests_failed++; $display("FAIL reset_pulses got %b want 00000",
                {rd_ack, rd_valid, wr_ready, swap_done, front_sel});
        end
        tests_run++;
        if ({sram_ce_n, sram_we_n, sram_oe_n} !== 3'b111) begin
            tests_failed++; $display("FAIL reset_strobes got %b want 111", {sram_ce_n, sram_we_n, sram_oe_n});
        end
        tests_run++;
        if (sram_addr !== 21'd0 || sram_wdata !== 24'd0 || rd_data !== 24'd0) begin
            tests_failed++; $display("FAIL reset_data got addr %0d wdata %h rdata %h want 0",
                sram_addr, sram_wdata, rd_data);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_only();
        rd_req = 1; rd_addr = 20'd5;
        @(negedge clk);
        tests_run++;
        if (rd_ack !== 1'b1 || sram_oe_n !== 1'b1) begin
            tests_failed++; $display("FAIL read_ack got ack %b oe_n %b want 1 1", rd_ack, sram_oe_n);
        end
        rd_req = 0;
        @(negedge clk);
        tests_run++;
        if (sram_addr !== 21'd5 || sram_oe_n !== 1'b0 || sram_ce_n !== 1'b0 || sram_we_n !== 1'b1) begin
            tests_failed++; $display("FAIL read_strobe got addr %0d ce %b oe %b we %b want 5 0 0 1",
                sram_addr, sram_ce_n, sram_oe_n, sram_we_n);
        end
        @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== 24'h5A5A5F) begin
            tests_failed++; $display("FAIL read_data got valid %b data %h want 1 5a5a5f", rd_valid, rd_data);
        end
        @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 24'h5A5A5F || sram_oe_n !== 1'b1) begin
            tests_failed++; $display("FAIL read_hold got valid %b data %h oe %b want 0 5a5a5f 1",
                rd_valid, rd_data, sram_oe_n);
        end
    endtask

    task automatic test_write_only();
        int base_pulses;
        base_pulses = wr_pulses;
        wr_valid = 1; wr_addr = 20'd10; wr_data = 24'hABCDEF;
        @(negedge clk);
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL write_ready got %b want 1", wr_ready);
        end
        wr_valid = 0;
        @(negedge clk);
        tests_run++;
        if (sram_addr !== 21'd307210 || sram_wdata !== 24'hABCDEF || sram_we_n !== 1'b0 || sram_ce_n !== 1'b0) begin
            tests_failed++; $display("FAIL write_strobe got addr %0d data %h we %b ce %b want 307210 abcdef 0 0",
                sram_addr, sram_wdata, sram_we_n, sram_ce_n);
        end
        @(negedge clk);
        tests_run++;
        if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b0 || sram_addr !== 21'd307210) begin
            tests_failed++; $display("FAIL write_recovery got we %b ce %b addr %0d want 1 0 307210",
                sram_we_n, sram_ce_n, sram_addr);
        end
        @(negedge clk);
        tests_run++;
        if (sram_ce_n !== 1'b1 || sram_wdata !== 24'hABCDEF || wr_pulses - base_pulses != 1) begin
            tests_failed++; $display("FAIL write_end got ce %b data %h pulses %0d want 1 abcdef 1",
                sram_ce_n, sram_wdata, wr_pulses - base_pulses);
        end
    endtask

    task automatic test_contention();
        int g, last_cyc, base_pulses;
        logic exp_w;
        g = 0; last_cyc = 0; base_pulses = wr_pulses;
        rd_req = 1; rd_addr = 20'd3; wr_valid = 1; wr_addr = 20'd7; wr_data = 24'h0F0F0F;
        for (int c = 0; c < 80 && g < 10; c++) begin
            @(negedge clk);
            if (rd_ack || wr_ready) begin
                exp_w = (g % 5 == 4);
                tests_run++;
                if (wr_ready !== exp_w || rd_ack !== !exp_w) begin
                    tests_failed++; $display("FAIL contention_grant%0d got rd %b wr %b want rd %b wr %b",
                        g, rd_ack, wr_ready, !exp_w, exp_w);
                end
                if (g > 0) begin
                    tests_run++;
                    if (c - last_cyc != 3) begin
                        tests_failed++; $display("FAIL contention_gap%0d got %0d want 3", g, c - last_cyc);
                    end
                end
                last_cyc = c;
                g++;
            end
        end
        rd_req = 0; wr_valid = 0;
        tests_run++;
        if (g != 10) begin
            tests_failed++; $display("FAIL contention_timeout got %0d grants want 10", g);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (wr_pulses - base_pulses != 2) begin
            tests_failed++; $display("FAIL contention_writes got %0d want 2", wr_pulses - base_pulses);
        end
    endtask

    task automatic test_swap();
        vsync = 1;
        @(negedge clk);
        vsync = 0;
        @(negedge clk);
        tests_run++;
        if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
            tests_failed++; $display("FAIL swap_idle_vsync got sel %b done %b want 0 0", front_sel, swap_done);
        end
        swap_req = 1;
        @(negedge clk);
        swap_req = 0;
        repeat (19) @(negedge clk);
        tests_run++;
        if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
            tests_failed++; $display("FAIL swap_wait got sel %b done %b want 0 0", front_sel, swap_done);
        end
        vsync = 1;
        @(negedge clk);
        vsync = 0;
        tests_run++;
        if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
            tests_failed++; $display("FAIL swap_apply got sel %b done %b want 1 1", front_sel, swap_done);
        end
        @(negedge clk);
        tests_run++;
        if (swap_done !== 1'b0 || front_sel !== 1'b1) begin
            tests_failed++; $display("FAIL swap_pulse got done %b sel %b want 0 1", swap_done, front_sel);
        end
        rd_req = 1; rd_addr = 20'd5;
        @(negedge clk);
        rd_req = 0;
        @(negedge clk);
        tests_run++;
        if (sram_addr !== 21'd307205 || sram_oe_n !== 1'b0) begin
            tests_failed++; $display("FAIL swap_read_addr got %0d oe %b want 307205 0", sram_addr, sram_oe_n);
        end
        @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== 24'h5EEA5F) begin
            tests_failed++; $display("FAIL swap_read_data got valid %b data %h want 1 5eea5f", rd_valid, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_swap_during_write();
        int base_pulses;
        base_pulses = wr_pulses;
        wr_valid = 1; wr_addr = 20'd10; wr_data = 24'h123456;
        @(negedge clk);
        wr_valid = 0; swap_req = 1; vsync = 1;
        @(negedge clk);
        swap_req = 0; vsync = 0;
        tests_run++;
        if (sram_we_n !== 1'b0 || sram_addr !== 21'd10 || sram_wdata !== 24'h123456 || front_sel !== 1'b1) begin
            tests_failed++; $display("FAIL wrswap_write got we %b addr %0d data %h sel %b want 0 10 123456 1",
                sram_we_n, sram_addr, sram_wdata, front_sel);
        end
        @(negedge clk);
        tests_run++;
        if (front_sel !== 1'b1 || swap_done !== 1'b0) begin
            tests_failed++; $display("FAIL wrswap_deferred got sel %b done %b want 1 0", front_sel, swap_done);
        end
        @(negedge clk);
        tests_run++;
        if (front_sel !== 1'b0 || swap_done !== 1'b1 || wr_pulses - base_pulses != 1) begin
            tests_failed++; $display("FAIL wrswap_apply got sel %b done %b pulses %0d want 0 1 1",
                front_sel, swap_done, wr_pulses - base_pulses);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int valid_seen;
        valid_seen = 0;
        swap_req = 1; vsync = 1;
        @(negedge clk);
        swap_req = 0; vsync = 0;
        tests_run++;
        if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
            tests_failed++; $display("FAIL same_cycle_swap got sel %b done %b want 1 1", front_sel, swap_done);
        end
        rd_req = 1; rd_addr = 20'd8;
        @(negedge clk);
        rd_req = 0;
        @(negedge clk);
        tests_run++;
        if (sram_oe_n !== 1'b0 || sram_addr !== 21'd307208) begin
            tests_failed++; $display("FAIL rst_read_setup got oe %b addr %0d want 0 307208", sram_oe_n, sram_addr);
        end
        n_rst = 1'b0;
        #1;
        tests_run++;
        if ({sram_ce_n, sram_we_n, sram_oe_n} !== 3'b111 || front_sel !== 1'b0) begin
            tests_failed++; $display("FAIL rst_abort got strobes %b sel %b want 111 0",
                {sram_ce_n, sram_we_n, sram_oe_n}, front_sel);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rd_valid) valid_seen++;
        end
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rd_valid) valid_seen++;
        end
        tests_run++;
        if (valid_seen != 0 || sram_ce_n !== 1'b1 || front_sel !== 1'b0) begin
            tests_failed++; $display("FAIL rst_no_valid got valids %0d ce %b sel %b want 0 1 0",
                valid_seen, sram_ce_n, front_sel);
        end
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_write_only();
        test_contention();
        test_swap();
        test_swap_during_write();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
